// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED SPI display model.
// Holds the page/column command subset, the parser state type and the
// default frame-buffer geometry.
package oled_pkg;

  // Default geometry: 4 pages of 8 pixel rows, 128 columns per page.
  localparam int unsigned NUM_PAGES_DEF   = 4;
  localparam int unsigned NUM_COLS_DEF    = 128;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Command bytes and command nibbles decoded by the parser.
  localparam logic [7:0] CMD_SET_PAGE  = 8'h22;
  localparam logic [3:0] CMD_COL_LO    = 4'h0;
  localparam logic [3:0] CMD_COL_HI    = 4'h1;
  localparam logic [3:0] CMD_PAGE_BASE = 4'hB;

  typedef enum logic {
    CMD      = 1'b0,
    PAGE_ARG = 1'b1
  } parser_state_t;

endpackage

// File: rtl/oled_spi_sink_if.sv
// Bus between the screen-update sequencer (master) and the OLED display
// model (slave).
//   CS, SCLK, SDO, DC : SPI link driven by the master
//   RX_VALID/RX_BYTE/RX_DC : received byte report
//   WR_EN/WR_ADDR/WR_DATA  : frame-buffer write port, WR_ADDR = {page, col}
//   PAGE, COL : current pointers;  ERR : protocol error pulse
interface oled_spi_sink_if
  import oled_pkg::*;
#(
  parameter int unsigned NUM_PAGES = NUM_PAGES_DEF,
  parameter int unsigned NUM_COLS  = NUM_COLS_DEF
);
  localparam int unsigned PAGE_W = $clog2(NUM_PAGES);
  localparam int unsigned COL_W  = $clog2(NUM_COLS);

  logic                    CS;
  logic                    SCLK;
  logic                    SDO;
  logic                    DC;
  logic                    RX_VALID;
  logic [7:0]              RX_BYTE;
  logic                    RX_DC;
  logic                    WR_EN;
  logic [PAGE_W+COL_W-1:0] WR_ADDR;
  logic [7:0]              WR_DATA;
  logic [PAGE_W-1:0]       PAGE;
  logic [COL_W-1:0]        COL;
  logic                    ERR;

  modport master (
    output CS, SCLK, SDO, DC,
    input  RX_VALID, RX_BYTE, RX_DC, WR_EN, WR_ADDR, WR_DATA, PAGE, COL, ERR
  );

  modport slave (
    input  CS, SCLK, SDO, DC,
    output RX_VALID, RX_BYTE, RX_DC, WR_EN, WR_ADDR, WR_DATA, PAGE, COL, ERR
  );

endinterface

// File: rtl/spi_rx_mode3.sv
// SPI mode 3 byte receiver oversampled on CLK.
//   CLK, RST          : system clock, synchronous active-high reset
//   CS, SCLK, SDO, DC : raw asynchronous SPI inputs
//   rx_byte_c/rx_dc_c : byte and DC as seen at the completing sample event
//   rx_valid_c        : high in the cycle of the 8th sample event
//   rx_abort_c        : high in the cycle CS rises with a partial byte held
// The *_c outputs are combinational so the parent can register them and
// report the byte exactly one CLK after the sample event.
module spi_rx_mode3 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       SDO,
  input  logic       DC,
  output logic [7:0] rx_byte_c,
  output logic       rx_dc_c,
  output logic       rx_valid_c,
  output logic       rx_abort_c
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdo_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   sdo_s;
  logic                   dc_s;
  logic                   cs_prev;
  logic                   sclk_prev;
  logic [6:0]             shreg_q;
  logic [2:0]             cnt_q;
  logic                   sample_c;
  logic                   cs_rise_c;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdo_s  = sdo_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  // Synchronizers; CS and SCLK reset to their idle-high level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      sdo_sync  <= '0;
      dc_sync   <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], SDO};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  // Sample on SCLK rising while selected; a CS rise can never share a cycle
  // with a sample event, so a byte completed on its 8th bit is never aborted.
  always_comb begin
    sample_c   = sclk_s & ~sclk_prev & ~cs_s;
    cs_rise_c  = cs_s & ~cs_prev;
    rx_byte_c  = {shreg_q, sdo_s};
    rx_dc_c    = dc_s;
    rx_valid_c = sample_c && (cnt_q == 3'd7);
    rx_abort_c = cs_rise_c && (cnt_q != 3'd0);
  end

  // Shift register and bit counter; only the low 7 bits need storing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (cs_rise_c) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (sample_c) begin
      shreg_q <= {shreg_q[5:0], sdo_s};
      cnt_q   <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/oled_spi_sink.sv
// Display-end model of the PmodOLED SPI link.
//   CLK, RST : system clock, synchronous active-high reset
//   bus      : slave side of oled_spi_sink_if (SPI in; received byte,
//              frame-buffer write port, page/column pointers, ERR out)
// Decodes the page/column command subset and writes data bytes into a
// page-addressed frame buffer. Parameters must match those of the bus.
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int unsigned NUM_PAGES   = NUM_PAGES_DEF,
  parameter int unsigned NUM_COLS    = NUM_COLS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic             CLK,
  input logic             RST,
  oled_spi_sink_if.slave  bus
);

  localparam int unsigned PAGE_W = $clog2(NUM_PAGES);
  localparam int unsigned COL_W  = $clog2(NUM_COLS);
  localparam int unsigned ADDR_W = PAGE_W + COL_W;

  logic [7:0]        rx_byte_c;
  logic              rx_dc_c;
  logic              rx_valid_c;
  logic              rx_abort_c;

  parser_state_t     state_q;
  logic              rx_valid_q;
  logic [7:0]        rx_byte_q;
  logic              rx_dc_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [PAGE_W-1:0] page_q;
  logic [COL_W-1:0]  col_q;
  logic              err_q;
  logic              ptr_load_q;
  logic [PAGE_W-1:0] page_nxt_q;
  logic [COL_W-1:0]  col_nxt_q;

  logic              is_set_page_c;
  logic              is_col_lo_c;
  logic              is_col_hi_c;
  logic              is_page_c;
  logic              page_arg_bad_c;
  logic [PAGE_W-1:0] page_cmd_c;
  logic [PAGE_W-1:0] page_arg_c;
  logic [7:0]        col_lo8_c;
  logic [7:0]        col_hi8_c;
  logic [COL_W-1:0]  col_lo_c;
  logic [COL_W-1:0]  col_hi_c;
  logic [COL_W-1:0]  col_inc_c;

  spi_rx_mode3 #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .CS         (bus.CS),
    .SCLK       (bus.SCLK),
    .SDO        (bus.SDO),
    .DC         (bus.DC),
    .rx_byte_c  (rx_byte_c),
    .rx_dc_c    (rx_dc_c),
    .rx_valid_c (rx_valid_c),
    .rx_abort_c (rx_abort_c)
  );

  // Command decode and candidate pointer values for the incoming byte.
  always_comb begin
    is_set_page_c  = (rx_byte_c == CMD_SET_PAGE);
    is_col_lo_c    = (rx_byte_c[7:4] == CMD_COL_LO);
    is_col_hi_c    = (rx_byte_c[7:4] == CMD_COL_HI) && !rx_byte_c[3];
    is_page_c      = (rx_byte_c[7:4] == CMD_PAGE_BASE) &&
                     (32'(rx_byte_c[3:0]) < NUM_PAGES);
    page_cmd_c     = PAGE_W'(rx_byte_c[3:0]);
    page_arg_c     = rx_byte_c[PAGE_W-1:0];
    page_arg_bad_c = (rx_byte_c >> PAGE_W) != 8'd0;
    col_lo8_c      = 8'(col_q);
    col_lo8_c[3:0] = rx_byte_c[3:0];
    col_lo_c       = COL_W'(col_lo8_c);
    col_hi8_c      = 8'(col_q);
    col_hi8_c[6:4] = rx_byte_c[2:0];
    col_hi_c       = COL_W'(col_hi8_c);
    col_inc_c      = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
  end

  // Parser: reports and writes are registered at the sample event; the
  // pointer update is staged one cycle so PAGE/COL still show the old
  // values during the RX_VALID cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CMD;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_dc_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      page_q     <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      ptr_load_q <= 1'b0;
      page_nxt_q <= '0;
      col_nxt_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      err_q      <= rx_abort_c;
      ptr_load_q <= 1'b0;

      if (ptr_load_q) begin
        page_q <= page_nxt_q;
        col_q  <= col_nxt_q;
      end

      if (rx_valid_c) begin
        rx_valid_q <= 1'b1;
        rx_byte_q  <= rx_byte_c;
        rx_dc_q    <= rx_dc_c;
        ptr_load_q <= 1'b1;
        page_nxt_q <= page_q;
        col_nxt_q  <= col_q;
        state_q    <= CMD;

        if (rx_dc_c) begin
          // Data is always written; it also breaks a pending page argument.
          wr_en_q   <= 1'b1;
          wr_addr_q <= {page_q, col_q};
          wr_data_q <= rx_byte_c;
          col_nxt_q <= col_inc_c;
          if (state_q == PAGE_ARG) err_q <= 1'b1;
        end else if (state_q == PAGE_ARG) begin
          page_nxt_q <= page_arg_c;
          if (page_arg_bad_c) err_q <= 1'b1;
        end else if (is_set_page_c) begin
          state_q <= PAGE_ARG;
        end else if (is_col_lo_c) begin
          col_nxt_q <= col_lo_c;
        end else if (is_col_hi_c) begin
          col_nxt_q <= col_hi_c;
        end else if (is_page_c) begin
          page_nxt_q <= page_cmd_c;
        end
      end
    end
  end

  assign bus.RX_VALID = rx_valid_q;
  assign bus.RX_BYTE  = rx_byte_q;
  assign bus.RX_DC    = rx_dc_q;
  assign bus.WR_EN    = wr_en_q;
  assign bus.WR_ADDR  = wr_addr_q;
  assign bus.WR_DATA  = wr_data_q;
  assign bus.PAGE     = page_q;
  assign bus.COL      = col_q;
  assign bus.ERR      = err_q;

endmodule
